// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic single-transfer initiator. Takes one read or write command
// over a valid/ready handshake, runs exactly one Wishbone cycle for it, and
// returns the read data and a status bit over a second valid/ready handshake.
// It is the host-side partner of the pixel_macro wbs_* slave port. Use it in
// the test harness and in the on-chip LA bridge.
//
// Optional feature:
//   WB_TIMEOUT_EN  when defined, a 16-bit watchdog ends a Wishbone cycle that
//                  gets no ack within TIMEOUT_CYCLES strobe cycles. That cycle
//                  reports rsp_err = 1. When undefined, the block waits for
//                  ack indefinitely and rsp_err is tied to 0.
//
// Parameters:
//   AW              address width
//   DW              data width (byte-select width is DW/8)
//   TIMEOUT_CYCLES  maximum strobe cycles without ack (1..65535), used only
//                   with WB_TIMEOUT_EN
//
// Ports:
//   wb_clk_i, wb_rst_i   clock (rising edge) and async active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_we/adr/dat/sel   command fields (1 = write)
//   rsp_valid/rsp_ready  response handshake
//   rsp_dat, rsp_err     read data (0 for writes/timeouts), timeout flag
//   wbm_*                Wishbone classic master signals
//   busy_o               high whenever the FSM is not in IDLE
//
// All outputs are registered.
//
// FSM states:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | cmd_ready high, waiting for cmd_valid
//   BUS     | cyc/stb asserted, waiting for ack (or timeout)
//   RESP    | rsp_valid high, holding response until rsp_ready
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,

    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,

    output logic            busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;

    // Single-cycle events decoded from the current state and inputs.
    logic cmd_accept;
    logic bus_ack;
    logic bus_timeout;
    logic bus_end;
    logic rsp_done;

`ifdef WB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;
`endif

    // -----------------------------------------------------------------------
    // Event decode and next state
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_accept = (state == ST_IDLE) && cmd_valid;
        bus_ack    = (state == ST_BUS)  && wbm_ack_i;
        rsp_done   = (state == ST_RESP) && rsp_ready;
`ifdef WB_TIMEOUT_EN
        // If ack and the terminal count arrive together, the ack wins.
        bus_timeout = (state == ST_BUS) && !wbm_ack_i && (to_cnt == TO_LAST);
`else
        bus_timeout = 1'b0;
`endif
        bus_end = bus_ack || bus_timeout;

        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_accept) state_nxt = ST_BUS;
            ST_BUS:  if (bus_end)    state_nxt = ST_RESP;
            ST_RESP: if (rsp_done)   state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and its registered status outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == ST_IDLE);
            busy_o    <= (state_nxt != ST_IDLE);
        end
    end

    // -----------------------------------------------------------------------
    // Wishbone master outputs
    // The address, data and select lines keep their last value after the
    // cycle ends. Only cyc, stb and we are cleared.
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else if (cmd_accept) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
        end else if (bus_end) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Response channel
    // rsp_dat and rsp_err stay valid until the next transfer ends. rsp_valid
    // qualifies them.
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
        end else if (bus_end) begin
            rsp_valid <= 1'b1;
            // wbm_we_o still holds the direction of the transfer that is ending.
            rsp_dat   <= (bus_ack && !wbm_we_o) ? wbm_dat_i : '0;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_err <= 1'b0;
        end else if (bus_end) begin
            rsp_err <= bus_timeout;
        end
    end

    // The counter counts strobe cycles that have no ack. It restarts on
    // every BUS entry.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
        end else if (cmd_accept) begin
            to_cnt <= '0;
        end else if ((state == ST_BUS) && !bus_end) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
